adc_sample_scheduler: RTL and testbench

Paces the serial ADC interface at a programmable audio sample rate. Each tick it runs exactly one conversion frame by holding the ADC core's clock-enable, detects the core's ready rising edge, and reformats the 12-bit word. It then buffers the word in a small FIFO that feeds the effects chain over a valid/ready handshake. Sticky status flags report FIFO overrun, missed ticks and ADC timeouts.

---
 rtl/adc_sample_scheduler.sv | 118 +++++++++++
 tb/tb_adc_sample_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: runs one ADC conversion frame per programmable sample tick
// and queues the bit-reversed words in a small FIFO with sticky status flags.
module adc_sample_scheduler #(
   parameter int PERIOD_W   = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64,
   parameter bit SIGNED_OUT = 1'b1
) (
   input  logic                        clock_i,
   input  logic                        reset_n_i,
   input  logic                        enable_i,
   input  logic [PERIOD_W-1:0]         period_i,
   input  logic                        clear_flags_i,
   output logic                        adc_clockenable_o,
   input  logic                        adc_ready_i,
   input  logic [11:0]                 adc_data_i,
   output logic [11:0]                 sample_data_o,
   output logic                        sample_valid_o,
   input  logic                        sample_ready_i,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
   output logic                        overrun_o,
   output logic                        missed_o,
   output logic                        timeout_o,
   output logic                        busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_CONVERT = 2'd2, S_CAPTURE = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d, reload;
   logic [WW-1:0]       wd_q, wd_d;
   logic                rdy_q, rdy_prev_q, tick, rise, in_cvt, wd_expire;
   logic [11:0]         data_q, rev, fmt, smp_q, smp_d;
   logic [11:0]         mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]       lvl_q, lvl_d;
   logic                push_req, push, pop, full;
   logic                ovr_q, ovr_d, mis_q, mis_d, tmo_q, tmo_d;

   assign reload = (period_i < PERIOD_W'(40)) ? PERIOD_W'(39) : period_i - PERIOD_W'(1);
   assign tick   = enable_i & (cnt_q == '0);
   assign cnt_d  = (!enable_i || tick) ? reload : cnt_q - PERIOD_W'(1);

   // ready/data are registered once, so the edge appears one cycle after ready is seen
   assign rise      = rdy_q & ~rdy_prev_q;
   assign in_cvt    = state_q == S_CONVERT;
   assign wd_expire = in_cvt & ~rise & (wd_q == WW'(TIMEOUT - 1));
   assign wd_d      = in_cvt ? wd_q + WW'(1) : '0;

   assign state_d = (state_q == S_IDLE)    ? (enable_i ? S_WAIT : S_IDLE) :
                    (state_q == S_WAIT)    ? (tick ? S_CONVERT : enable_i ? S_WAIT : S_IDLE) :
                    (state_q == S_CONVERT) ? (rise ? S_CAPTURE : wd_expire ? S_WAIT : S_CONVERT) :
                                             (enable_i ? S_WAIT : S_IDLE);

   assign rev   = {<<{data_q}};
   assign fmt   = rev ^ {SIGNED_OUT, 11'd0};
   assign smp_d = (in_cvt & rise) ? fmt : smp_q;

   assign push_req = state_q == S_CAPTURE;
   assign pop      = sample_valid_o & sample_ready_i;
   assign full     = lvl_q == LW'(FIFO_DEPTH);
   assign push     = push_req & (~full | pop);
   assign wr_d     = push ? wr_q + AW'(1) : wr_q;
   assign rd_d     = pop ? rd_q + AW'(1) : rd_q;
   assign lvl_d    = lvl_q + LW'(push) - LW'(pop);

   assign ovr_d = (push_req & ~push) | (ovr_q & ~clear_flags_i);
   assign mis_d = (tick & (in_cvt | push_req)) | (mis_q & ~clear_flags_i);
   assign tmo_d = wd_expire | (tmo_q & ~clear_flags_i);

   // reset gates the clock-enable combinationally so a frame stops at once
   assign adc_clockenable_o = reset_n_i & in_cvt & ~rise;
   assign busy_o            = in_cvt;
   assign sample_valid_o    = lvl_q != '0;
   assign sample_data_o     = sample_valid_o ? mem_q[rd_q] : '0;
   assign fifo_level_o      = lvl_q;
   assign overrun_o         = ovr_q;
   assign missed_o          = mis_q;
   assign timeout_o         = tmo_q;

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= PERIOD_W'(39);
         wd_q       <= '0;
         rdy_q      <= 1'b0;
         rdy_prev_q <= 1'b0;
         data_q     <= '0;
         smp_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         lvl_q      <= '0;
         ovr_q      <= 1'b0;
         mis_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wd_q       <= wd_d;
         rdy_q      <= adc_ready_i;
         rdy_prev_q <= rdy_q;
         data_q     <= adc_data_i;
         smp_q      <= smp_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         lvl_q      <= lvl_d;
         ovr_q      <= ovr_d;
         mis_q      <= mis_d;
         tmo_q      <= tmo_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (push) mem_q[wr_q] <= smp_q;
   end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: directed checks of tick pacing, frame timing,
// FIFO overrun/drain order, missed ticks, watchdog, reset and stop behaviour.
module tb_adc_sample_scheduler;
   logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clear_flags = 1'b0;
   logic [15:0] period = 16'd100;
   logic        adc_ready = 1'b0, adc_stuck = 1'b0, sample_ready = 1'b1;
   logic [11:0] adc_word = 12'h001;
   logic        ce, valid, busy, overrun, missed, timeout;
   logic [11:0] sample_data;
   logic [2:0]  level;
   int          adc_frame = 35, acnt = 0, cyc = 0, n_chk = 0, n_pass = 0;
   int          e, h0, h1, h2;
   logic [11:0] words [6] = '{12'h001, 12'h000, 12'hABC, 12'hFFF, 12'h555, 12'h0F0};
   logic [11:0] expd  [4] = '{12'h000, 12'h800, 12'hBD5, 12'h7FF};

   adc_sample_scheduler dut (
      .clock_i(clk), .reset_n_i(reset_n), .enable_i(enable), .period_i(period),
      .clear_flags_i(clear_flags), .adc_clockenable_o(ce), .adc_ready_i(adc_ready),
      .adc_data_i(adc_word), .sample_data_o(sample_data), .sample_valid_o(valid),
      .sample_ready_i(sample_ready), .fifo_level_o(level), .overrun_o(overrun),
      .missed_o(missed), .timeout_o(timeout), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC core: raises ready after adc_frame enabled clocks, parks when enable drops
   always @(posedge clk) begin
      if (!ce) begin
         acnt      <= 0;
         adc_ready <= 1'b0;
      end else if (!adc_stuck) begin
         acnt <= acnt + 1;
         if (acnt == adc_frame - 1) adc_ready <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic pick(input int sel);
      return sel == 0 ? ce : sel == 1 ? valid : busy;
   endfunction

   task automatic wait_on(input string tag, input int sel, input logic val, output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         if (pick(sel) == val) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
      if (at < 0) check(tag, 32'(pick(sel)), 32'(val));
   endtask

   initial begin
      step(3);
      check("rst_ce", ce, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_level", level, 0);
      check("rst_data", sample_data, 0);
      check("rst_flags", {overrun, missed, timeout}, 0);
      reset_n = 1'b1;
      step(3);
      enable = 1'b1;
      e = cyc;
      wait_on("a_ce", 0, 1'b1, h0);
      check("a_first_ce", h0 - e, 100);
      wait_on("a_valid", 1, 1'b1, h1);
      check("a_frame_to_valid", h1 - h0, 38);
      check("a_data", sample_data, 12'h000);
      check("a_level", level, 1);
      step(1);
      for (int k = 0; k < 2; k++) begin
         wait_on("a_valid_n", 1, 1'b1, h0);
         check("a_period", h0 - h1, 100);
         check("a_data_n", sample_data, 12'h000);
         h1 = h0;
         step(1);
      end
      check("a_flags", {overrun, missed, timeout}, 0);
      sample_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_on("b_busy", 2, 1'b1, h0);
         adc_word = words[k];
         wait_on("b_ce_fall", 0, 1'b0, h0);
         wait_on("b_busy_fall", 2, 1'b0, h0);
         if (k == 0) begin
            step(2);
            check("b_head_first", sample_data, 12'h000);
         end
      end
      step(3);
      check("b_level_full", level, 4);
      check("b_overrun", overrun, 1);
      check("b_other_flags", {missed, timeout}, 0);
      check("b_head_stable", sample_data, 12'h000);
      sample_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("b_drain", sample_data, expd[k]);
         step(1);
      end
      check("b_empty", valid, 0);
      clear_flags = 1'b1;
      step(1);
      clear_flags = 1'b0;
      check("b_clear", overrun, 0);
      enable = 1'b0;
      period = 16'd20;
      step(2);
      enable = 1'b1;
      e = cyc;
      wait_on("c_ce", 0, 1'b1, h0);
      check("c_first_ce", h0 - e, 40);
      for (int k = 0; k < 3; k++) begin
         wait_on("c_fall", 0, 1'b0, h1);
         wait_on("c_rise", 0, 1'b1, h1);
         check("c_interval", h1 - h0, 40);
         h0 = h1;
      end
      check("c_no_missed", missed, 0);
      wait_on("c_fall35", 0, 1'b0, h1);
      adc_frame = 45;
      wait_on("c_rise45", 0, 1'b1, h1);
      check("c_interval45a", h1 - h0, 40);
      h0 = h1;
      wait_on("c_fall45", 0, 1'b0, h1);
      wait_on("c_rise45b", 0, 1'b1, h1);
      check("c_interval45b", h1 - h0, 80);
      check("c_missed", missed, 1);
      wait_on("d_fall", 0, 1'b0, h1);
      adc_stuck = 1'b1;
      adc_frame = 35;
      wait_on("d_rise", 0, 1'b1, h0);
      check("d_tmo_pre", timeout, 0);
      wait_on("d_expire", 0, 1'b0, h1);
      check("d_ce_len", h1 - h0, 64);
      check("d_timeout", timeout, 1);
      check("d_busy", busy, 0);
      check("d_no_push", level, 0);
      wait_on("d_retry", 0, 1'b1, h1);
      check("d_retry_gap", h1 - h0, 80);
      adc_stuck = 1'b0;
      sample_ready = 1'b0;
      wait_on("e_fall", 0, 1'b0, h1);
      wait_on("e_busy_fall", 2, 1'b0, h1);
      step(3);
      check("e_level_pre", level, 1);
      wait_on("e_rise", 0, 1'b1, h0);
      step(10);
      reset_n = 1'b0;
      period = 16'd100;
      #1;
      check("e_ce_drop", ce, 0);
      step(1);
      check("e_busy", busy, 0);
      check("e_valid", valid, 0);
      check("e_level", level, 0);
      check("e_data", sample_data, 0);
      check("e_flags", {overrun, missed, timeout}, 0);
      step(2);
      sample_ready = 1'b1;
      reset_n = 1'b1;
      e = cyc;
      wait_on("e_resume", 0, 1'b1, h0);
      check("e_resume_gap", h0 - e, 40);
      step(5);
      adc_word = 12'h0F0;
      enable = 1'b0;
      wait_on("f_fall", 0, 1'b0, h1);
      check("f_ce_len", h1 - h0, 36);
      wait_on("f_valid", 1, 1'b1, h2);
      check("f_valid_lat", h2 - h1, 2);
      check("f_data", sample_data, 12'h8F0);
      h1 = 0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         h1 += int'(ce | busy);
      end
      check("f_no_frames", h1, 0);
      check("f_level", level, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
